// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and default window base for dmem_responder.
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam logic [31:0] DMEM_BASE = 32'h10010000;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the CPU MEM stage and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane extraction/extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        sgn,
    input  logic [31:0] raw,
    output logic [31:0] ldata
);
    logic [31:0] sh;
    assign be = st_size == SZ_BYTE ? 4'b0001 << st_lane :
                st_size == SZ_HALF ? (st_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wlane = st_size == SZ_BYTE ? {4{wdata[7:0]}} :
                   st_size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    assign sh = raw >> {ld_lane, 3'b000};
    assign ldata = ld_size == SZ_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
                   ld_size == SZ_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with sized access, window decode and wait states.
// Define DMEM_CLEAR_EN to zero the RAM one word per cycle after every reset.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 2048,
    parameter logic [31:0] BASE        = DMEM_BASE,
    parameter int          WAIT_CYCLES = 0
) (
    input logic             clk_in,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word, wlane, ldata;
    logic [AW-1:0] idx;
    logic [32:0] addr_x;
    logic [3:0] be;
    logic [1:0] r_size, r_lane;
    logic r_we, r_err, r_signed, accept, err, clr_done;
    assign accept = bus.req_valid & bus.req_ready;
    assign addr_x = {1'b0, bus.req_addr};
    assign idx = AW'((bus.req_addr - BASE) >> 2);
    // 33-bit window compare so BASE+4*DEPTH cannot wrap
    assign err = bus.req_size == SZ_RSVD
              || (bus.req_size == SZ_HALF && bus.req_addr[0])
              || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
              || addr_x < {1'b0, BASE}
              || addr_x >= {1'b0, BASE} + 33'(4 * DEPTH);
    dmem_lane_align u_align (
        .st_size(bus.req_size),
        .st_lane(bus.req_addr[1:0]),
        .wdata(bus.req_wdata),
        .be(be),
        .wlane(wlane),
        .ld_size(r_size),
        .ld_lane(r_lane),
        .sgn(r_signed),
        .raw(rd_word),
        .ldata(ldata)
    );
`ifdef DMEM_CLEAR_EN
    logic [AW-1:0] clr_idx;
    assign clr_done = clr_idx == AW'(DEPTH - 1);
    always_ff @(posedge clk_in)
        clr_idx <= (reset || state != CLEAR) ? '0 : clr_idx + AW'(1);
`else
    assign clr_done = 1'b1;
`endif
    always_ff @(posedge clk_in) begin
        if (reset) begin
`ifdef DMEM_CLEAR_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= accept ? 4'(WAIT_CYCLES) : state == WAIT ? cnt - 4'd1 : cnt;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE;
            WAIT:    state_nx = cnt == 4'd1 ? RESP : WAIT;
            RESP:    state_nx = IDLE;
            CLEAR:   state_nx = clr_done ? IDLE : CLEAR;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_in)
        if (accept) begin
            r_we     <= bus.req_we;
            r_err    <= err;
            r_size   <= bus.req_size;
            r_lane   <= bus.req_addr[1:0];
            r_signed <= bus.req_signed;
            rd_word  <= mem[idx];
        end
    always_ff @(posedge clk_in) begin
`ifdef DMEM_CLEAR_EN
        if (state == CLEAR && !reset) mem[clr_idx] <= '0;
`endif
        if (accept && bus.req_we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
    end
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_err   = state == RESP && r_err;
    assign bus.rsp_rdata = (state == RESP && !r_err && !r_we) ? ldata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed checks of two responders (0 and 3 wait states) against a byte-array model.
module tb_dmem_responder;
    import dmem_pkg::*;
    localparam int D = 16;
    localparam logic [31:0] B = 32'h10010000;
`ifdef DMEM_CLEAR_EN
    localparam int CLR = D;
`else
    localparam int CLR = 0;
`endif
    logic clk = 0, rst = 0;
    logic v = 0, we = 0, sg = 0, sel = 0;
    logic [31:0] a = 0, d = 0;
    logic [1:0] sz = 0;
    int checks = 0, errors = 0;
    logic [7:0] mb [2][4*D];
    logic rdy, rv, re;
    logic [31:0] rd;
    dmem_responder_if ia();
    dmem_responder_if ib();
    dmem_responder #(.DEPTH(D), .BASE(B), .WAIT_CYCLES(0)) u_a (.clk_in(clk), .reset(rst), .bus(ia.slave));
    dmem_responder #(.DEPTH(D), .BASE(B), .WAIT_CYCLES(3)) u_b (.clk_in(clk), .reset(rst), .bus(ib.slave));
    always #5 clk = ~clk;
    assign ia.req_valid = v & ~sel;
    assign ib.req_valid = v & sel;
    assign ia.req_we = we;
    assign ib.req_we = we;
    assign ia.req_addr = a;
    assign ib.req_addr = a;
    assign ia.req_wdata = d;
    assign ib.req_wdata = d;
    assign ia.req_size = sz;
    assign ib.req_size = sz;
    assign ia.req_signed = sg;
    assign ib.req_signed = sg;
    assign rdy = sel ? ib.req_ready : ia.req_ready;
    assign rv  = sel ? ib.rsp_valid : ia.rsp_valid;
    assign re  = sel ? ib.rsp_err : ia.rsp_err;
    assign rd  = sel ? ib.rsp_rdata : ia.rsp_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic merr(input logic [31:0] ad, input logic [1:0] s);
        longint lo = longint'(B), x = longint'(ad);
        return s == 2'b11 || (s == 2'b01 && ad[0]) || (s == 2'b10 && ad[1:0] != 2'b00)
            || x < lo || x >= lo + 4 * D;
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] ad, input logic [1:0] s, input logic g);
        int off = int'(ad - B);
        int n = 1 << s;
        logic [31:0] r = 0;
        for (int i = 0; i < n; i++) r = r | (32'(mb[sel][off+i]) << (8 * i));
        if (g && n == 1 && r[7]) r = r | 32'hFFFFFF00;
        if (g && n == 2 && r[15]) r = r | 32'hFFFF0000;
        return r;
    endfunction

    task automatic mstore(input logic [31:0] ad, input logic [31:0] wd, input logic [1:0] s);
        int off = int'(ad - B);
        logic [31:0] t = wd;
        for (int i = 0; i < (1 << s); i++) begin
            mb[sel][off+i] = t[7:0];
            t = t >> 8;
        end
    endtask

    task automatic settle(output int busy);
        busy = 0;
        while (!ia.req_ready && busy < 4 * D) begin
            @(negedge clk);
            busy++;
        end
        if (CLR > 0)
            for (int s = 0; s < 2; s++)
                for (int i = 0; i < 4 * D; i++) mb[s][i] = 8'h00;
    endtask

    task automatic do_reset(output int busy);
        @(negedge clk);
        rst = 1;
        v = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        settle(busy);
    endtask

    // called at a falling edge; returns at a falling edge with the responder idle
    task automatic xact(input logic w, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [1:0] s, input logic g, output logic [31:0] got);
        int n;
        logic e;
        logic [31:0] exp;
        e = merr(ad, s);
        exp = (w || e) ? 32'h0 : mload(ad, s, g);
        v = 1; we = w; a = ad; d = wd; sz = s; sg = g;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready", rdy, 1);
        @(posedge clk);
        #1;
        v = 0; we = 1'($urandom); a = $urandom; d = $urandom; sz = 2'($urandom); sg = 1'($urandom);
        if (w && !e) mstore(ad, wd, s);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv && n < 20);
        check("latency", n, sel ? 4 : 1);
        check("rdata", rd, exp);
        check("err", re, e);
        check("busy", rdy, 0);
        got = rd;
        @(negedge clk);
        check("pulse", rv, 0);
        check("idle", rdy, 1);
    endtask

    initial begin
        int busy;
        logic [31:0] got, ad;
        do_reset(busy);
        check("clear_len", busy, CLR);
        check("rst_ready", ia.req_ready, 1);
        check("rst_valid", ia.rsp_valid, 0);
        check("rst_rdata", ia.rsp_rdata, 0);
        check("rst_err", ia.rsp_err, 0);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < D; w++) xact(1, B + 32'(4 * w), $urandom, SZ_WORD, 0, got);
        end
        sel = 0;
        xact(1, B + 4, 32'hDEADBEEF, SZ_WORD, 0, got);
        xact(0, B + 4, 0, SZ_WORD, 0, got);
        check("t1_word", got, 32'hDEADBEEF);
        xact(1, B + 7, 32'h12345680, SZ_BYTE, 0, got);
        xact(0, B + 7, 0, SZ_BYTE, 1, got);
        check("t2_sbyte", got, 32'hFFFFFF80);
        xact(0, B + 7, 0, SZ_BYTE, 0, got);
        check("t2_ubyte", got, 32'h00000080);
        xact(0, B + 4, 0, SZ_WORD, 0, got);
        check("t2_word", got, 32'h80ADBEEF);
        xact(0, B + 1, 0, SZ_HALF, 0, got);
        xact(0, B + 2, 0, SZ_WORD, 0, got);
        xact(0, 32'h1000FFFC, 0, SZ_WORD, 0, got);
        xact(1, 32'h10012000, 32'hCAFEF00D, SZ_WORD, 0, got);
        xact(1, B + 6, 32'h0000AAAA, SZ_RSVD, 0, got);
        xact(0, B, 0, SZ_WORD, 0, got);
        xact(0, B + 4, 0, SZ_WORD, 0, got);
        check("t3_unchanged", got, 32'h80ADBEEF);
        // back-to-back with valid held high on the 3-wait-state responder
        sel = 1;
        v = 1; we = 0; a = B; sz = SZ_WORD; sg = 0;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("hold_valid_%0d", k), rv, (k == 4 || k == 9));
            check($sformatf("hold_ready_%0d", k), rdy, (k == 5));
        end
        v = 0;
        xact(0, B, 0, SZ_WORD, 0, got);
        // reset during WAIT drops the pending response
        v = 1; we = 0; a = B + 8; sz = SZ_WORD;
        @(posedge clk);
        #1;
        v = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_ready", rdy, CLR == 0);
        for (int k = 0; k < 8; k++) begin
            check("abort_norsp", rv, 0);
            @(negedge clk);
        end
        settle(busy);
        for (int i = 0; i < 80; i++) begin
            sel = 1'(i);
            ad = B - 8 + 32'($urandom_range(0, 4 * D + 15));
            xact(1'($urandom), ad, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), got);
        end
`ifdef DMEM_CLEAR_EN
        do_reset(busy);
        check("t6_clear_len", busy, D);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int w = 0; w < D; w++) begin
                xact(0, B + 32'(4 * w), 0, SZ_WORD, 0, got);
                check("t6_zero", got, 0);
            end
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got %0d exp 0", 1);
        $fatal(1, "timeout");
    end
endmodule
